// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// Define UART_TX_ARB_LOCK_EN to hold the grant on one requester until it sends a byte with last=1.
module uart_tx_arb #(
    parameter int BDIV = 434,
    parameter int GAP  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    input  logic [7:0]  r0_data,
    input  logic        r0_last,
    output logic        r0_ready,
    input  logic        r1_valid,
    input  logic [7:0]  r1_data,
    input  logic        r1_last,
    output logic        r1_ready,
    output logic [7:0]  uart_wdata,
    output logic        uart_we,
    output logic [15:0] uart_bdiv,
    input  logic        uart_busy,
    output logic        owner,
    output logic        active
);

    localparam logic [15:0] BDIV_W     = 16'(BDIV);
    localparam logic [7:0]  GAP_RELOAD = 8'(GAP - 1);
    localparam bit          HAS_GAP    = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        owner_q, owner_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        lock_s;
    logic        elig0_s, elig1_s;
    logic        grant0_s, grant1_s;
    logic        accept_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic        lock_q, lock_d;
    logic        sel_last_s;

    assign lock_s     = lock_q;
    assign sel_last_s = grant0_s ? r0_last : r1_last;

    // Lock flag: set by a non-final byte, cleared by the final byte of a message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock next-state follows the last flag of each accepted byte.
    always_comb begin
        lock_d = lock_q;
        if (accept_s) begin
            lock_d = ~sel_last_s;
        end else begin
            lock_d = lock_q;
        end
    end
`else
    logic unused_last_s;

    assign lock_s        = 1'b0;
    assign unused_last_s = r0_last ^ r1_last;
`endif

    // Grant: while locked only the current owner is eligible; on contention the non-owner wins.
    always_comb begin
        elig0_s  = r0_valid & (~lock_s | ~owner_q);
        elig1_s  = r1_valid & (~lock_s | owner_q);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            if (elig0_s && elig1_s) begin
                grant0_s = owner_q;
                grant1_s = ~owner_q;
            end else begin
                grant0_s = elig0_s;
                grant1_s = elig1_s;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s = grant0_s | grant1_s;
    assign r0_ready = grant0_s;
    assign r1_ready = grant1_s;

    // Next-state and datapath update for the IDLE/SEND/WAIT/GAP sequence.
    always_comb begin
        state_d   = state_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        owner_d   = owner_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    wdata_d = grant0_s ? r0_data : r1_data;
                    owner_d = grant1_s;
                    we_d    = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!uart_busy) begin
                    if (HAS_GAP) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            owner_q   <= 1'b1;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_q   <= owner_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // The load strobe is registered, so it is high exactly for the SEND cycle.
    assign uart_wdata = wdata_q;
    assign uart_we    = we_q;
    assign owner      = owner_q;
    assign active     = (state_q != ST_IDLE);
    assign uart_bdiv  = BDIV_W;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: default instance against a transaction/timing model, plus a GAP=5, BDIV=27 instance.
module tb_uart_tx_arb;

    localparam int GAP_G  = 5;
    localparam int BUSY_G = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_last, r1_valid, r1_last, r0_ready, r1_ready;
    logic [7:0]  r0_data, r1_data, uart_wdata;
    logic        uart_we, uart_busy, owner, active;
    logic [15:0] uart_bdiv;
    logic        g_r0_valid, g_r0_ready, g_r1_ready, g_uart_we, g_uart_busy, g_owner, g_active;
    logic [7:0]  g_uart_wdata;
    logic [15:0] g_uart_bdiv;

    always #5 clk = ~clk;

    uart_tx_arb u_dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
        .uart_wdata(uart_wdata), .uart_we(uart_we), .uart_bdiv(uart_bdiv),
        .uart_busy(uart_busy), .owner(owner), .active(active)
    );

    uart_tx_arb #(.BDIV(27), .GAP(GAP_G)) u_dut_g (
        .clk(clk), .reset(reset),
        .r0_valid(g_r0_valid), .r0_data(8'hC3), .r0_last(1'b1), .r0_ready(g_r0_ready),
        .r1_valid(1'b0), .r1_data(8'h00), .r1_last(1'b0), .r1_ready(g_r1_ready),
        .uart_wdata(g_uart_wdata), .uart_we(g_uart_we), .uart_bdiv(g_uart_bdiv),
        .uart_busy(g_uart_busy), .owner(g_owner), .active(g_active)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          idle_at, we_at, bfrom, bto, busy_len;
    int          g_bfrom, g_bto, g_fall;
    bit          g_busy_prev, g_stream, busy_rand, rnd_en, owner_m, lock_m;
    bit          en0 = 1'b1;
    bit          en1 = 1'b1;
    logic [7:0]  last_byte;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  obs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a byte accepted at cycle a strobes at a+1, the uart is busy a+2..a+1+B,
    // and the arbiter is back in IDLE at a+B+3 (GAP=0 instance).
    task automatic model_check();
        bit         idle_m, e0, e1, g0, g1;
        logic [8:0] ent;
        idle_m = (cyc >= idle_at);
        chk("active", 32'(active), 32'(!idle_m));
        chk("uart_we", 32'(uart_we), 32'(cyc == we_at));
        chk("wdata", 32'(uart_wdata), 32'(last_byte));
        chk("owner", 32'(owner), 32'(owner_m));
        e0 = idle_m && r0_valid && (!lock_m || !owner_m);
        e1 = idle_m && r1_valid && (!lock_m || owner_m);
        if (e0 && e1) begin
            g0 = owner_m;
            g1 = !owner_m;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        chk("r0_ready", 32'(r0_ready), 32'(g0));
        chk("r1_ready", 32'(r1_ready), 32'(g1));
        if (uart_we) obs.push_back(uart_wdata);
        if (g0 || g1) begin
            ent       = g0 ? q0.pop_front() : q1.pop_front();
            last_byte = ent[7:0];
            owner_m   = g1;
`ifdef UART_TX_ARB_LOCK_EN
            lock_m    = !ent[8];
`endif
            if (busy_rand) busy_len = $urandom_range(0, 6);
            we_at   = cyc + 1;
            bfrom   = cyc + 2;
            bto     = cyc + 1 + busy_len;
            idle_at = cyc + busy_len + 3;
        end
        if (g_uart_we) begin
            g_bfrom = cyc + 1;
            g_bto   = cyc + BUSY_G;
        end
        if (g_busy_prev && !g_uart_busy) g_fall = cyc;
        g_busy_prev = g_uart_busy;
        if (g_r0_ready && g_fall >= 0) begin
            chk("gap_len", 32'(cyc - g_fall - 1), 32'(GAP_G));
            g_fall = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        uart_busy   = (cyc >= bfrom) && (cyc <= bto);
        g_uart_busy = (cyc >= g_bfrom) && (cyc <= g_bto);
        if (rnd_en) begin
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
            if (q0.size() == 0) q0.push_back(9'($urandom));
            if (q1.size() == 0) q1.push_back(9'($urandom));
        end
        r0_valid   = en0 && (q0.size() > 0);
        r0_data    = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        r0_last    = (q0.size() > 0) ? q0[0][8] : 1'b0;
        r1_valid   = en1 && (q1.size() > 0);
        r1_data    = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        r1_last    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        g_r0_valid = g_stream;
        @(negedge clk);
        model_check();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_we", 32'(uart_we), 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        chk("rst_wdata", 32'(uart_wdata), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        r0_valid    = 1'b0;
        r1_valid    = 1'b0;
        g_r0_valid  = 1'b0;
        uart_busy   = 1'b0;
        g_uart_busy = 1'b0;
        reset       = 1'b0;
        bfrom = 1; bto = 0; g_bfrom = 1; g_bto = 0; g_fall = -1; g_busy_prev = 1'b0;
        owner_m = 1'b1; lock_m = 1'b0; last_byte = 8'h00; idle_at = cyc; we_at = -1;
        @(negedge clk);
        chk("post_rst_we", 32'(uart_we), 32'd0);
        chk("post_rst_active", 32'(active), 32'd0);
    endtask

    initial begin : main
        logic [7:0] exp31[4];
        logic [7:0] exp33[3];
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; r0_last = 1'b0; r1_last = 1'b0;
        r0_data = 8'h00; r1_data = 8'h00; uart_busy = 1'b0;
        g_r0_valid = 1'b0; g_uart_busy = 1'b0;
        busy_len = 3; busy_rand = 1'b0; rnd_en = 1'b0; g_stream = 1'b0;
        apply_reset();
        chk("bdiv_default", 32'(uart_bdiv), 32'd434);
        chk("bdiv_override", 32'(g_uart_bdiv), 32'd27);

        // Single request after reset.
        obs.delete();
        q0.push_back({1'b1, 8'h41});
        repeat (10) step();
        chk("t30_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) chk("t30_byte", 32'(obs[0]), 32'h41);
        chk("t30_owner", 32'(owner), 32'd0);

        // Both requesters held, uart busy 10 cycles.
        apply_reset();
        busy_len = 10; g_stream = 1'b1; obs.delete();
        exp31[0] = 8'h30; exp31[1] = 8'h31; exp31[2] = 8'h30; exp31[3] = 8'h31;
        repeat (2) begin
            q0.push_back({1'b1, 8'h30});
            q1.push_back({1'b1, 8'h31});
        end
        for (int i = 0; i < 200 && obs.size() < 4; i++) step();
        chk("t31_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("t31_byte", 32'(obs[i]), 32'(exp31[i]));
        repeat (20) step();

        // Message lock behaviour.
        apply_reset();
        busy_len = 2; obs.delete();
`ifdef UART_TX_ARB_LOCK_EN
        exp33[0] = 8'h48; exp33[1] = 8'h49; exp33[2] = 8'h5A;
`else
        exp33[0] = 8'h48; exp33[1] = 8'h5A; exp33[2] = 8'h49;
`endif
        q0.push_back({1'b0, 8'h48});
        q0.push_back({1'b1, 8'h49});
        q1.push_back({1'b1, 8'h5A});
        for (int i = 0; i < 200 && obs.size() < 3; i++) step();
        chk("t33_count", 32'(obs.size()), 32'd3);
        for (int i = 0; i < 3 && i < obs.size(); i++) chk("t33_byte", 32'(obs[i]), 32'(exp33[i]));
        repeat (20) step();

        // Reset while waiting on a busy uart, with both requesters pending.
        busy_len = 10;
        q0.push_back({1'b1, 8'h77});
        step();
        q0.push_back({1'b1, 8'h55});
        q1.push_back({1'b1, 8'hAA});
        repeat (4) step();
        chk("t34_busy_pre", 32'(uart_busy), 32'd1);
        apply_reset();
        obs.delete();
        for (int i = 0; i < 50 && obs.size() < 1; i++) step();
        chk("t34_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) chk("t34_byte", 32'(obs[0]), 32'h55);
        chk("t34_owner", 32'(owner), 32'd0);
        repeat (40) step();

        // Randomised traffic with random uart busy times and a reset in the middle.
        busy_rand = 1'b1; rnd_en = 1'b1;
        repeat (1500) step();
        apply_reset();
        repeat (1500) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
